ddr_rd_arbiter: RTL and testbench
=================================

Name: ddr_rd_arbiter

Overview:
- Shares one DDR read channel (address + data) between REQ_NUM read clients, e.g. ddr2pe index/data/parameter loaders.
- Round-robin arbitration on the address channel.
- An in-order tag FIFO records the requester and burst length of each issued read, and routes returned data beats back to the owning client.
- Sits between the load engines and the external ddr*_in_* port pair.

Parameters:
- REQ_NUM, 4, number of read clients (2..8).
- OUTSTANDING, 4, maximum issued-but-not-fully-returned bursts; tag FIFO depth, power of two.
- Widths DDR_W, DDR_ADDR_W, BURST_W come from GLOBAL_PARAM.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- req_addr  in  REQ_NUM x DDR_ADDR_W  per-client read address
- req_size  in  REQ_NUM x BURST_W  per-client burst; beats = size + 1
- req_addr_valid  in  REQ_NUM  per-client address request
- req_addr_ready  out  REQ_NUM  per-client address accept
- req_data  out  DDR_W  returned data, broadcast to all clients
- req_valid  out  REQ_NUM  per-client data beat valid
- req_ready  in  REQ_NUM  per-client data beat accept
- ddr_addr  out  DDR_ADDR_W  DDR read address
- ddr_size  out  BURST_W  DDR burst size
- ddr_addr_valid  out  1  DDR address valid
- ddr_addr_ready  in  1  DDR address accept
- ddr_data  in  DDR_W  DDR read data
- ddr_valid  in  1  DDR data valid
- ddr_ready  out  1  DDR data accept
- busy  out  1  high when a grant is pending or the tag FIFO is non-empty

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE; rr_ptr=0; FIFO empty; beat_cnt=0.
  - All outputs 0: ddr_addr_valid, req_addr_ready, req_valid, ddr_ready, busy.
  - Reset mid-burst discards all tags. Data beats still arriving afterwards are not accepted (ddr_ready=0).
- Address FSM, two states:
  - IDLE: if any req_addr_valid and the FIFO is not full, pick the first valid client scanning rr_ptr, rr_ptr+1, ... mod REQ_NUM. Register gnt_id and the chosen addr/size, then go to ISSUE. If the FIFO is full, stay in IDLE, even if a pop occurs this cycle.
  - ISSUE: ddr_addr_valid=1, with ddr_addr/ddr_size held from the registered values. On ddr_addr_ready:
    - req_addr_ready[gnt_id]=1 for exactly that cycle (combinational from ddr_addr_ready, state and gnt_id).
    - Push {gnt_id, size} into the FIFO.
    - rr_ptr = (gnt_id+1) mod REQ_NUM.
    - Go to IDLE.
  - Minimum issue interval is 2 cycles. Address latency: valid seen at IDLE edge -> ddr_addr_valid on the next cycle.
  - Clients must hold req_addr_valid, addr and size stable until req_addr_ready. Dropping valid while in ISSUE is a protocol violation; the already latched request is still issued.
- Data routing (combinational through the FIFO head):
  - head = {hid, hsize}.
  - req_valid[i] = ddr_valid & !empty & (hid==i).
  - ddr_ready = !empty & req_ready[hid].
  - req_data = ddr_data.
  - With the FIFO empty: ddr_ready=0, req_valid=0.
- Beat counting:
  - On each ddr_valid & ddr_ready, beat_cnt increments.
  - When beat_cnt == hsize: pop the head and clear beat_cnt in the same cycle.
  - Next cycle the new head routes; no bubble is required beyond the register update.
- Simultaneous push and pop: both take effect; count is unchanged.
- FIFO pointers wrap mod OUTSTANDING. Count width is bw(OUTSTANDING+1).
- Back-to-back bursts to the same client are returned in issue order. Bursts to different clients are returned strictly in issue order: a slow client stalls all others (head-of-line blocking by design).
- busy = (state==ISSUE) | !empty.

Test Plan:
- Single request: client 1 requests addr=0x1000, size=3; ddr_addr_ready held high -> ddr_addr_valid=1 the cycle after the request, ddr_addr=0x1000, ddr_size=3, req_addr_ready[1] pulses once. Then 4 data beats -> req_valid[1]=1 for all 4, others 0. busy falls after the 4th beat.
- Round-robin: all 4 clients hold valid, rr_ptr=0 -> grants in order 0,1,2,3,0. Each client is granted once per 4 issues.
- FIFO full: OUTSTANDING=4 with no data returned -> exactly 4 addresses issued, 5th request waits. One full burst then returns -> 5th issues.
- Backpressure: req_ready[2]=0 during a client-2 burst -> ddr_ready=0, no beat lost. Release -> remaining beats delivered, beat_cnt continues from its held value.
- Interleaved sizes: client 0 size=0 then client 3 size=7 -> 1 beat to client 0, then 8 beats to client 3. Head switches with no dropped beat.
- Reset mid-burst: rst=0 after 2 of 4 beats -> next cycle all outputs 0, FIFO empty. A subsequent fresh request operates normally.

Source files
------------

// File: rtl/ddr_rd_arbiter.sv
// Round-robin arbiter sharing one DDR read channel between REQ_NUM clients.
// An in-order tag FIFO routes returned beats back to the client that issued the burst.
module ddr_rd_arbiter #(
    parameter int unsigned REQ_NUM     = 4,
    parameter int unsigned OUTSTANDING = 4,
    parameter int unsigned DDR_W       = 64,
    parameter int unsigned DDR_ADDR_W  = 32,
    parameter int unsigned BURST_W     = 4
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic [REQ_NUM-1:0][DDR_ADDR_W-1:0]    i_req_addr,
    input  logic [REQ_NUM-1:0][BURST_W-1:0]       i_req_size,
    input  logic [REQ_NUM-1:0]                    i_req_addr_valid,
    output logic [REQ_NUM-1:0]                    o_req_addr_ready,
    output logic [DDR_W-1:0]                      o_req_data,
    output logic [REQ_NUM-1:0]                    o_req_valid,
    input  logic [REQ_NUM-1:0]                    i_req_ready,
    output logic [DDR_ADDR_W-1:0]                 o_ddr_addr,
    output logic [BURST_W-1:0]                    o_ddr_size,
    output logic                                  o_ddr_addr_valid,
    input  logic                                  i_ddr_addr_ready,
    input  logic [DDR_W-1:0]                      i_ddr_data,
    input  logic                                  i_ddr_valid,
    output logic                                  o_ddr_ready,
    output logic                                  o_busy
);

    localparam int unsigned ID_W  = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
    localparam int unsigned FA_W  = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);

    typedef enum logic {
        StIdle,
        StIssue
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ID_W-1:0]         r_rr_ptr;
    logic [ID_W-1:0]         r_gnt_id;
    logic [DDR_ADDR_W-1:0]   r_addr;
    logic [BURST_W-1:0]      r_size;

    logic [ID_W-1:0]         r_tag_id   [OUTSTANDING];
    logic [BURST_W-1:0]      r_tag_size [OUTSTANDING];
    logic [FA_W-1:0]         r_wptr;
    logic [FA_W-1:0]         r_rptr;
    logic [CNT_W-1:0]        r_count;
    logic [BURST_W-1:0]      r_beat_cnt;

    logic                    w_pick_found;
    logic [ID_W-1:0]         w_pick_id;
    logic                    w_load;
    logic                    w_issue_hs;
    logic                    w_empty;
    logic                    w_full;
    logic [ID_W-1:0]         w_head_id;
    logic [BURST_W-1:0]      w_head_size;
    logic                    w_beat;
    logic                    w_pop;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CNT_W'(OUTSTANDING));
    assign w_head_id   = r_tag_id[r_rptr];
    assign w_head_size = r_tag_size[r_rptr];

    // First valid client at or after the round-robin pointer.
    always_comb begin
        int unsigned idx;
        w_pick_found = 1'b0;
        w_pick_id    = '0;
        for (int unsigned k = 0; k < REQ_NUM; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= REQ_NUM) begin
                idx = idx - REQ_NUM;
            end
            if (!w_pick_found && i_req_addr_valid[idx]) begin
                w_pick_found = 1'b1;
                w_pick_id    = ID_W'(idx);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_issue_hs  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_pick_found && !w_full) begin
                    w_load      = 1'b1;
                    w_state_nxt = StIssue;
                end
            end
            StIssue: begin
                if (i_ddr_addr_ready) begin
                    w_issue_hs  = 1'b1;
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        o_req_addr_ready = '0;
        if (w_issue_hs) begin
            o_req_addr_ready[r_gnt_id] = 1'b1;
        end
        o_req_valid = '0;
        for (int unsigned i = 0; i < REQ_NUM; i++) begin
            o_req_valid[i] = i_ddr_valid && !w_empty && (w_head_id == ID_W'(i));
        end
    end

    assign o_ddr_addr_valid = (r_state == StIssue);
    assign o_ddr_addr       = r_addr;
    assign o_ddr_size       = r_size;
    assign o_req_data       = i_ddr_data;
    assign o_ddr_ready      = !w_empty && i_req_ready[w_head_id];
    assign o_busy           = (r_state == StIssue) || !w_empty;

    assign w_beat = i_ddr_valid && o_ddr_ready;
    assign w_pop  = w_beat && (r_beat_cnt == w_head_size);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state  <= StIdle;
            r_rr_ptr <= '0;
            r_gnt_id <= '0;
            r_addr   <= '0;
            r_size   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_gnt_id <= w_pick_id;
                r_addr   <= i_req_addr[w_pick_id];
                r_size   <= i_req_size[w_pick_id];
            end
            if (w_issue_hs) begin
                r_rr_ptr <= (r_gnt_id == ID_W'(REQ_NUM - 1)) ? '0 : r_gnt_id + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_beat_cnt <= '0;
        end else begin
            if (w_issue_hs) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr     <= r_rptr + 1'b1;
                r_beat_cnt <= '0;
            end else if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
            unique case ({w_issue_hs, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Tag storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge i_clk) begin
        if (w_issue_hs) begin
            r_tag_id[r_wptr]   <= r_gnt_id;
            r_tag_size[r_wptr] <= r_size;
        end
    end

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Directed bench for ddr_rd_arbiter: queue-based reference model checked every cycle,
// plus literal expectations on grant order, beat counts and returned data.
module tb_ddr_rd_arbiter;

    localparam int REQ_NUM     = 4;
    localparam int OUTSTANDING = 4;
    localparam int DDR_W       = 32;
    localparam int DDR_ADDR_W  = 32;
    localparam int BURST_W     = 4;

    logic                               clk = 1'b0;
    logic                               rst = 1'b0;
    logic [REQ_NUM-1:0][DDR_ADDR_W-1:0] req_addr;
    logic [REQ_NUM-1:0][BURST_W-1:0]    req_size;
    logic [REQ_NUM-1:0]                 req_addr_valid;
    logic [REQ_NUM-1:0]                 req_addr_ready;
    logic [DDR_W-1:0]                   req_data;
    logic [REQ_NUM-1:0]                 req_valid;
    logic [REQ_NUM-1:0]                 req_ready;
    logic [DDR_ADDR_W-1:0]              ddr_addr;
    logic [BURST_W-1:0]                 ddr_size;
    logic                               ddr_addr_valid;
    logic                               ddr_addr_ready;
    logic [DDR_W-1:0]                   ddr_data;
    logic                               ddr_valid;
    logic                               ddr_ready;
    logic                               busy;

    always #5 clk = ~clk;

    ddr_rd_arbiter #(
        .REQ_NUM     (REQ_NUM),
        .OUTSTANDING (OUTSTANDING),
        .DDR_W       (DDR_W),
        .DDR_ADDR_W  (DDR_ADDR_W),
        .BURST_W     (BURST_W)
    ) u_dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_req_addr       (req_addr),
        .i_req_size       (req_size),
        .i_req_addr_valid (req_addr_valid),
        .o_req_addr_ready (req_addr_ready),
        .o_req_data       (req_data),
        .o_req_valid      (req_valid),
        .i_req_ready      (req_ready),
        .o_ddr_addr       (ddr_addr),
        .o_ddr_size       (ddr_size),
        .o_ddr_addr_valid (ddr_addr_valid),
        .i_ddr_addr_ready (ddr_addr_ready),
        .i_ddr_data       (ddr_data),
        .i_ddr_valid      (ddr_valid),
        .o_ddr_ready      (ddr_ready),
        .o_busy           (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_q(input string name, input int act[$], input int exp[$]);
        chk({name, "_len"}, 64'(act.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            chk(name, (i < act.size()) ? 64'(act[i]) : 64'hDEAD, 64'(exp[i]));
        end
    endtask

    // Client request driver: each client keeps valid high while it has pending requests.
    int cl_pend [REQ_NUM];
    initial begin
        logic [REQ_NUM-1:0] hs_v;
        for (int i = 0; i < REQ_NUM; i++) cl_pend[i] = 0;
        forever begin
            @(negedge clk);
            hs_v = req_addr_ready & {REQ_NUM{rst}};
            @(posedge clk);
            #2;
            for (int i = 0; i < REQ_NUM; i++) begin
                if (hs_v[i] && cl_pend[i] > 0) cl_pend[i]--;
                req_addr_valid[i] = (cl_pend[i] > 0);
            end
        end
    end

    // Observation log used by the literal checks.
    int hs_cnt;
    int gnt_log[$];
    int iss_addr[$];
    int iss_size[$];
    int d2[$];
    int bcnt [REQ_NUM];
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (ddr_addr_valid && ddr_addr_ready) begin
                    hs_cnt++;
                    iss_addr.push_back(int'(ddr_addr));
                    iss_size.push_back(int'(ddr_size));
                end
                for (int i = 0; i < REQ_NUM; i++) begin
                    if (req_addr_ready[i]) gnt_log.push_back(i);
                    if (req_valid[i] && req_ready[i]) begin
                        bcnt[i]++;
                        if (i == 2) d2.push_back(int'(req_data));
                    end
                end
            end
        end
    end

    // Reference model: outstanding bursts as a queue, one pending grant, rr pointer as int.
    typedef struct {
        int id;
        int size;
    } tag_t;

    initial begin
        tag_t               tq[$];
        bit                 m_live;
        bit                 m_issuing;
        int                 m_gnt;
        int                 m_rr;
        int                 m_beats;
        logic [DDR_ADDR_W-1:0] m_addr;
        int                 m_size;
        bit                 head_ok;
        int                 hid;
        logic [REQ_NUM-1:0] exp_rv;
        logic [REQ_NUM-1:0] exp_ar;
        bit                 exp_dr;
        bit                 full;
        bit                 found;
        int                 idx;
        m_live = 0; m_issuing = 0; m_gnt = 0; m_rr = 0; m_beats = 0; m_addr = '0; m_size = 0;
        exp_dr = 0;
        forever begin
            @(negedge clk);
            if (m_live) begin
                head_ok = (tq.size() > 0);
                hid     = head_ok ? tq[0].id : 0;
                exp_rv  = '0;
                if (head_ok && ddr_valid) exp_rv[hid] = 1'b1;
                exp_dr  = head_ok && req_ready[hid];
                exp_ar  = '0;
                if (m_issuing && ddr_addr_ready) exp_ar[m_gnt] = 1'b1;
                chk("ddr_addr_valid", 64'(ddr_addr_valid), 64'(m_issuing));
                if (m_issuing) begin
                    chk("ddr_addr", 64'(ddr_addr), 64'(m_addr));
                    chk("ddr_size", 64'(ddr_size), 64'(m_size));
                end
                chk("req_addr_ready", 64'(req_addr_ready), 64'(exp_ar));
                chk("req_valid", 64'(req_valid), 64'(exp_rv));
                chk("ddr_ready", 64'(ddr_ready), 64'(exp_dr));
                chk("req_data", 64'(req_data), 64'(ddr_data));
                chk("busy", 64'(busy), 64'(m_issuing || head_ok));
            end
            if (!rst) begin
                m_live = 1; tq.delete(); m_beats = 0; m_issuing = 0; m_rr = 0;
            end else if (m_live) begin
                full = (tq.size() >= OUTSTANDING);
                if (ddr_valid && exp_dr) begin
                    m_beats++;
                    if (m_beats == tq[0].size + 1) begin
                        void'(tq.pop_front());
                        m_beats = 0;
                    end
                end
                if (m_issuing) begin
                    if (ddr_addr_ready) begin
                        tq.push_back('{m_gnt, m_size});
                        m_rr      = (m_gnt + 1) % REQ_NUM;
                        m_issuing = 0;
                    end
                end else if (!full) begin
                    found = 0;
                    for (int k = 0; k < REQ_NUM; k++) begin
                        idx = (m_rr + k) % REQ_NUM;
                        if (!found && req_addr_valid[idx]) begin
                            found     = 1;
                            m_issuing = 1;
                            m_gnt     = idx;
                            m_addr    = req_addr[idx];
                            m_size    = int'(req_size[idx]);
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_logs();
        hs_cnt = 0;
        gnt_log.delete();
        iss_addr.delete();
        iss_size.delete();
        d2.delete();
        for (int i = 0; i < REQ_NUM; i++) bcnt[i] = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
    endtask

    task automatic wait_hs(input int target, input int budget);
        int g;
        g = 0;
        while (hs_cnt < target && g < budget) begin
            tick();
            g++;
        end
        chk("wait_issue", 64'(hs_cnt >= target), 64'(1));
    endtask

    task automatic send_beats(input int n, input int base);
        int sent;
        int guard;
        sent = 0;
        guard = 0;
        ddr_valid = 1'b1;
        ddr_data  = DDR_W'(base);
        while (sent < n && guard < 200) begin
            @(negedge clk);
            if (ddr_ready) sent++;
            @(posedge clk);
            #1;
            ddr_data = DDR_W'(base + sent);
            guard++;
        end
        ddr_valid = 1'b0;
        chk("beats_sent", 64'(sent), 64'(n));
    endtask

    initial begin
        req_addr       = '0;
        req_size       = '0;
        req_addr_valid = '0;
        req_ready      = '1;
        ddr_addr_ready = 1'b1;
        ddr_data       = '0;
        ddr_valid      = 1'b0;
        clr_logs();
        rst = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_addr_valid", 64'(ddr_addr_valid), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_ddr_ready", 64'(ddr_ready), 64'(0));
        tick();
        rst = 1'b1;

        // Single request from client 1.
        clr_logs();
        req_addr[1] = 32'h1000;
        req_size[1] = 4'd3;
        cl_pend[1]  = 1;
        wait_hs(1, 20);
        chk_q("t1_gnt", gnt_log, '{1});
        chk_q("t1_addr", iss_addr, '{32'h1000});
        chk_q("t1_size", iss_size, '{3});
        send_beats(4, 32'hA0);
        @(negedge clk);
        chk("t1_busy_after", 64'(busy), 64'(0));
        chk_q("t1_beats", '{bcnt[0], bcnt[1], bcnt[2], bcnt[3]}, '{0, 4, 0, 0});
        tick();

        // Round-robin from rr_ptr=0 with every client requesting.
        do_reset();
        clr_logs();
        for (int i = 0; i < REQ_NUM; i++) begin
            req_addr[i] = DDR_ADDR_W'(32'h2000 + i * 16);
            req_size[i] = '0;
        end
        cl_pend[0] = 2; cl_pend[1] = 1; cl_pend[2] = 1; cl_pend[3] = 1;
        fork
            send_beats(5, 32'hB0);
            wait_hs(5, 100);
        join
        chk_q("t2_gnt", gnt_log, '{0, 1, 2, 3, 0});
        chk_q("t2_beats", '{bcnt[0], bcnt[1], bcnt[2], bcnt[3]}, '{2, 1, 1, 1});

        // FIFO full: four issues, fifth waits until one burst returns.
        clr_logs();
        for (int i = 0; i < REQ_NUM; i++) req_size[i] = 4'd1;
        cl_pend[0] = 2; cl_pend[1] = 1; cl_pend[2] = 1; cl_pend[3] = 1;
        repeat (30) tick();
        chk("t3_issued_full", 64'(hs_cnt), 64'(4));
        @(negedge clk);
        chk("t3_addr_valid_full", 64'(ddr_addr_valid), 64'(0));
        chk("t3_busy_full", 64'(busy), 64'(1));
        tick();
        send_beats(2, 32'hC0);
        wait_hs(5, 20);
        chk("t3_issued_after", 64'(hs_cnt), 64'(5));
        send_beats(8, 32'hC8);
        @(negedge clk);
        chk("t3_busy_after", 64'(busy), 64'(0));
        chk_q("t3_beats", '{bcnt[0], bcnt[1], bcnt[2], bcnt[3]}, '{4, 2, 2, 2});
        tick();

        // Backpressure from client 2 mid-burst.
        clr_logs();
        req_addr[2] = 32'h4000;
        req_size[2] = 4'd3;
        cl_pend[2]  = 1;
        wait_hs(1, 20);
        fork
            send_beats(4, 32'hD0);
            begin
                repeat (2) tick();
                req_ready[2] = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("t4_stall_ddr_ready", 64'(ddr_ready), 64'(0));
                    tick();
                end
                req_ready[2] = 1'b1;
            end
        join
        chk_q("t4_data", d2, '{32'hD0, 32'hD1, 32'hD2, 32'hD3});

        // Size 0 to client 0 followed by size 7 to client 3.
        clr_logs();
        req_addr[0] = 32'h5000; req_size[0] = 4'd0;
        req_addr[3] = 32'h5100; req_size[3] = 4'd7;
        cl_pend[0] = 1;
        wait_hs(1, 20);
        cl_pend[3] = 1;
        wait_hs(2, 20);
        send_beats(9, 32'hE0);
        chk_q("t5_gnt", gnt_log, '{0, 3});
        chk_q("t5_beats", '{bcnt[0], bcnt[1], bcnt[2], bcnt[3]}, '{1, 0, 0, 8});

        // Reset after 2 of 4 beats, then a fresh request.
        clr_logs();
        req_addr[1] = 32'h6000; req_size[1] = 4'd3;
        cl_pend[1] = 1;
        wait_hs(1, 20);
        send_beats(2, 32'hF0);
        chk("t6_beats_pre", 64'(bcnt[1]), 64'(2));
        rst = 1'b0;
        tick();
        ddr_valid = 1'b1;
        @(negedge clk);
        chk("t6_ddr_ready", 64'(ddr_ready), 64'(0));
        chk("t6_req_valid", 64'(req_valid), 64'(0));
        chk("t6_busy", 64'(busy), 64'(0));
        chk("t6_addr_valid", 64'(ddr_addr_valid), 64'(0));
        tick();
        rst = 1'b1;
        ddr_valid = 1'b0;
        clr_logs();
        req_addr[2] = 32'h7000; req_size[2] = 4'd1;
        cl_pend[2] = 1;
        wait_hs(1, 20);
        send_beats(2, 32'h70);
        @(negedge clk);
        chk("t6_busy_after", 64'(busy), 64'(0));
        chk_q("t6_data", d2, '{32'h70, 32'h71});
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
